score_display_ctrl: RTL

- Owns the player score and the session best score, and selects which value feeds the shared two-digit seven-segment decoder.
- Time-multiplexes the decoder's ones/tens patterns onto one shared segment bus with one-hot digit selects and a blanking gap between digits.
- Sits between game-logic hit/miss pulses and the board display pins; the decoder is instantiated alongside at top level.

---
 rtl/score_display_ctrl_pkg.sv | 9 +
 rtl/score_display_ctrl_counter.sv | 34 +++
 rtl/score_display_ctrl.sv | 69 ++++++
 3 files changed

// File: rtl/score_display_ctrl_pkg.sv
// score_display_ctrl_pkg: shared scan states and display constants
package score_display_ctrl_pkg;
  typedef enum logic [1:0] {ONES, GAP1, TENS, GAP2} scan_state_e;
  localparam logic [1:0] DIG_ONES = 2'b01;
  localparam logic [1:0] DIG_TENS = 2'b10;
  localparam logic [1:0] DIG_OFF = 2'b00;
  localparam logic [6:0] SEG_OFF = 7'b0;
  localparam logic [4:0] SCORE_MAX = 5'd31;
endpackage

// File: rtl/score_display_ctrl_counter.sv
// score_counter: saturating player score plus session best
//   in  clk, rst (async, active-high), clear, hit, miss
//   out score[4:0], best[4:0]
module score_counter
  import score_display_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       hit,
  input  logic       miss,
  output logic [4:0] score,
  output logic [4:0] best
);
  logic [4:0] score_q, score_d, best_q, best_d;
  always_comb begin
    score_d = clear ? 5'd0 :
              (hit && !miss && score_q != SCORE_MAX) ? score_q + 5'd1 :
              (miss && !hit && score_q != 5'd0) ? score_q - 5'd1 : score_q;
    // best tracks the incoming score so both update on the same edge
    best_d = (score_d > best_q) ? score_d : best_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
      best_q <= '0;
    end else begin
      score_q <= score_d;
      best_q <= best_d;
    end
  end
  assign score = score_q;
  assign best = best_q;
endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: score ownership and two-digit multiplexed seven-segment scan
//   in  clk, rst (async, active-high), clear, hit, miss, show_best, disp_en
//   in  ones_seg[6:0], tens_seg[6:0] from the external decoder
//   out disp_val[4:0] to the decoder, score[4:0], best[4:0]
//   out seg[6:0] (gfedcba), dig_sel[1:0] ([0] ones, [1] tens)
module score_display_ctrl
  import score_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       hit,
  input  logic       miss,
  input  logic       show_best,
  input  logic       disp_en,
  input  logic [6:0] ones_seg,
  input  logic [6:0] tens_seg,
  output logic [4:0] disp_val,
  output logic [4:0] score,
  output logic [4:0] best,
  output logic [6:0] seg,
  output logic [1:0] dig_sel
);
  localparam int MAXL = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW = (MAXL > 1) ? $clog2(MAXL) : 1;
  scan_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, last;
  logic [6:0] seg_q, seg_d;
  logic [1:0] dig_sel_q, dig_sel_d;
  score_counter u_score (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .hit  (hit),
    .miss (miss),
    .score(score),
    .best (best)
  );
  assign disp_val = show_best ? best : score;
  always_comb begin
    last = (state_q == ONES || state_q == TENS) ? CW'(SCAN_DIV - 1) : CW'(BLANK_CYCLES - 1);
    // states are encoded in scan order, so advancing is an increment
    state_d = !disp_en ? ONES : (cnt_q == last) ? scan_state_e'(state_q + 2'd1) : state_q;
    cnt_d = (!disp_en || cnt_q == last) ? '0 : cnt_q + CW'(1);
    dig_sel_d = !disp_en ? DIG_OFF : (state_q == ONES) ? DIG_ONES :
                (state_q == TENS) ? DIG_TENS : DIG_OFF;
    seg_d = !disp_en ? SEG_OFF : (state_q == ONES) ? ones_seg :
            (state_q == TENS && !(LZ_BLANK && disp_val < 5'd10)) ? tens_seg : SEG_OFF;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ONES;
      cnt_q <= '0;
      seg_q <= SEG_OFF;
      dig_sel_q <= DIG_OFF;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      seg_q <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end
  assign seg = seg_q;
  assign dig_sel = dig_sel_q;
endmodule
